// File: rtl/sfw_pkg.sv
// rtl/sfw_pkg.sv - shared state encoding and address helpers for sensor_frame_writer
// Contents: sfw_state_e (frame FSM states), sfw_bpc (bytes per channel),
//           sfw_byte_off (offset of byte b of channel k), sfw_seq_off (offset of sequence byte).
package sfw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        SETUP,
        STROBE,
        GAP,
        SEQ_SETUP,
        SEQ_STROBE
    } sfw_state_e;

    function automatic int sfw_bpc(input int dw);
        return dw / 8;
    endfunction

    function automatic int sfw_byte_off(input int k, input int bpc, input int b);
        return k * bpc + b;
    endfunction

    // The sequence byte sits right after the last channel slot, masked or not.
    function automatic int sfw_seq_off(input int nch, input int bpc);
        return nch * bpc;
    endfunction

endpackage

// File: rtl/sfw_tick_gen.sv
// rtl/sfw_tick_gen.sv - free-running frame tick divider
// Ports: clk100m (clock), rst (sync active-high reset), tick (high while count == TICK_DIV-1).
module sfw_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk100m,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk100m) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/sensor_frame_writer.sv
// rtl/sensor_frame_writer.sv - periodic snapshot of sensor channels written bytewise into a register file
// Ports: clk100m/rst (clock, sync active-high reset); ch_data/ch_mask (channel values and enables);
//        clr_ovr (clear overrun); datain/addrin/en (byte write port, one-cycle strobe);
//        busy (frame in progress); overrun (sticky: tick arrived while busy).
module sensor_frame_writer
    import sfw_pkg::*;
#(
    parameter int NCH       = 6,
    parameter int DW        = 16,
    parameter int AW        = 8,
    parameter int ADDR_BASE = 0,
    parameter int TICK_DIV  = 100000,
    parameter int EN_GAP    = 2
) (
    input  logic                clk100m,
    input  logic                rst,
    input  logic [NCH*DW-1:0]   ch_data,
    input  logic [NCH-1:0]      ch_mask,
    input  logic                clr_ovr,
    output logic [7:0]          datain,
    output logic [AW-1:0]       addrin,
    output logic                en,
    output logic                busy,
    output logic                overrun
);

    localparam int BPC = sfw_bpc(DW);
    localparam logic [AW-1:0] SEQ_ADDR = AW'(ADDR_BASE + sfw_seq_off(NCH, BPC));

    if ((ADDR_BASE + NCH * BPC > (1 << AW) - 1) || (DW % 8 != 0)) begin : g_bad_cfg
        $error("sensor_frame_writer: address map does not fit AW or DW is not a byte multiple");
    end

    function automatic logic [AW-1:0] byte_addr(input logic [4:0] k, input logic [1:0] b);
        return AW'(ADDR_BASE + sfw_byte_off(int'(k), BPC, int'(b)));
    endfunction

    function automatic logic [7:0] byte_data(input logic [NCH*DW-1:0] d, input logic [4:0] k,
                                             input logic [1:0] b);
        return d[int'(k) * DW + int'(b) * 8 +: 8];
    endfunction

    logic tick;

    sfw_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk100m (clk100m),
        .rst     (rst),
        .tick    (tick)
    );

    sfw_state_e        state_q, state_d;
    logic [7:0]        datain_q, datain_d;
    logic [AW-1:0]     addrin_q, addrin_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        seq_q, seq_d;
    logic [4:0]        ch_q, ch_d;
    logic [1:0]        byte_q, byte_d;
    logic [2:0]        gap_q, gap_d;
    logic              last_q, last_d;     // current GAP follows the sequence byte
    logic [NCH*DW-1:0] data_sh_q, data_sh_d;
    logic [NCH-1:0]    mask_sh_q, mask_sh_d;

    // First enabled channel of the live mask (used in SNAP), next enabled after ch_q in the shadow.
    logic       first_ok, nxt_ok;
    logic [4:0] first_ch, nxt_ch;

    // Where the frame goes after the current byte's strobe (and gap).
    sfw_state_e    adv_state;
    logic [7:0]    adv_data;
    logic [AW-1:0] adv_addr;
    logic [4:0]    adv_ch;
    logic [1:0]    adv_byte;

    always_comb begin
        first_ok = 1'b0;
        first_ch = '0;
        nxt_ok   = 1'b0;
        nxt_ch   = '0;
        // Descending scans so the lowest matching index wins.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (ch_mask[k]) begin
                first_ok = 1'b1;
                first_ch = 5'(k);
            end
            if (mask_sh_q[k] && (k > int'(ch_q))) begin
                nxt_ok = 1'b1;
                nxt_ch = 5'(k);
            end
        end

        adv_ch   = ch_q;
        adv_byte = byte_q;
        if (int'(byte_q) < BPC - 1) begin
            adv_byte  = byte_q + 2'd1;
            adv_state = SETUP;
            adv_data  = byte_data(data_sh_q, ch_q, byte_q + 2'd1);
            adv_addr  = byte_addr(ch_q, byte_q + 2'd1);
        end else if (nxt_ok) begin
            adv_ch    = nxt_ch;
            adv_byte  = '0;
            adv_state = SETUP;
            adv_data  = byte_data(data_sh_q, nxt_ch, 2'd0);
            adv_addr  = byte_addr(nxt_ch, 2'd0);
        end else begin
            adv_state = SEQ_SETUP;
            adv_data  = seq_q;
            adv_addr  = SEQ_ADDR;
        end
    end

    always_comb begin
        state_d   = state_q;
        datain_d  = datain_q;
        addrin_d  = addrin_q;
        en_d      = 1'b0;
        seq_d     = seq_q;
        ch_d      = ch_q;
        byte_d    = byte_q;
        gap_d     = gap_q;
        last_d    = last_q;
        data_sh_d = data_sh_q;
        mask_sh_d = mask_sh_q;

        // A dropped tick outranks a simultaneous clear.
        overrun_d = overrun_q;
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end
        if (tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SNAP;
                end
            end
            SNAP: begin
                data_sh_d = ch_data;
                mask_sh_d = ch_mask;
                last_d    = 1'b0;
                byte_d    = '0;
                if (first_ok) begin
                    ch_d     = first_ch;
                    datain_d = byte_data(ch_data, first_ch, 2'd0);
                    addrin_d = byte_addr(first_ch, 2'd0);
                    state_d  = SETUP;
                end else begin
                    datain_d = seq_q;
                    addrin_d = SEQ_ADDR;
                    state_d  = SEQ_SETUP;
                end
            end
            SETUP: begin
                en_d    = 1'b1;
                state_d = STROBE;
            end
            STROBE: begin
                gap_d = '0;
                if (EN_GAP == 0) begin
                    state_d  = adv_state;
                    datain_d = adv_data;
                    addrin_d = adv_addr;
                    ch_d     = adv_ch;
                    byte_d   = adv_byte;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + 3'd1;
                if (int'(gap_q) == EN_GAP - 1) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = adv_state;
                        datain_d = adv_data;
                        addrin_d = adv_addr;
                        ch_d     = adv_ch;
                        byte_d   = adv_byte;
                    end
                end
            end
            SEQ_SETUP: begin
                en_d    = 1'b1;
                state_d = SEQ_STROBE;
            end
            SEQ_STROBE: begin
                seq_d   = seq_q + 8'd1;
                last_d  = 1'b1;
                gap_d   = '0;
                state_d = (EN_GAP == 0) ? IDLE : GAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk100m) begin
        if (rst) begin
            state_q   <= IDLE;
            datain_q  <= '0;
            addrin_q  <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            seq_q     <= '0;
            ch_q      <= '0;
            byte_q    <= '0;
            gap_q     <= '0;
            last_q    <= 1'b0;
            data_sh_q <= '0;
            mask_sh_q <= '0;
        end else begin
            state_q   <= state_d;
            datain_q  <= datain_d;
            addrin_q  <= addrin_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            seq_q     <= seq_d;
            ch_q      <= ch_d;
            byte_q    <= byte_d;
            gap_q     <= gap_d;
            last_q    <= last_d;
            data_sh_q <= data_sh_d;
            mask_sh_q <= mask_sh_d;
        end
    end

    assign datain  = datain_q;
    assign addrin  = addrin_q;
    assign en      = en_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: doc/sensor_frame_writer.md
SENSOR_FRAME_WRITER -- requirements
Module: sensor_frame_writer

Interface
REQ-001 SHALL have parameter NCH, default 6, meaning number of sensor channels (1..16).
REQ-002 SHALL have parameter DW, default 16, meaning channel width in bits (multiple of 8, 8..32).
REQ-003 SHALL have parameter AW, default 8, meaning register-file address width.
REQ-004 SHALL have parameter ADDR_BASE, default 0, meaning address of channel 0 byte 0.
REQ-005 SHALL have parameter TICK_DIV, default 100000, meaning clk100m cycles per frame (1 kHz at 100 MHz).
REQ-006 SHALL have parameter EN_GAP, default 2, meaning idle cycles after each strobe (0..7).
REQ-007 SHALL have port clk100m, input, 1, meaning the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-009 SHALL have port ch_data, input, NCH*DW, meaning channel k at bits [k*DW +: DW].
REQ-010 SHALL have port ch_mask, input, NCH, meaning bit k=1 enables channel k.
REQ-011 SHALL have port clr_ovr, input, 1, meaning clears the overrun flag.
REQ-012 SHALL have port datain, output, 8, meaning write data byte.
REQ-013 SHALL have port addrin, output, AW, meaning write address.
REQ-014 SHALL have port en, output, 1, meaning one-cycle write strobe.
REQ-015 SHALL have port busy, output, 1, meaning a frame is in progress.
REQ-016 SHALL have port overrun, output, 1, meaning sticky flag for a tick dropped while busy.

Function
REQ-017 SHALL run a free-running tick counter 0..TICK_DIV-1 that raises tick in the cycle the count equals TICK_DIV-1, then wraps to 0.
REQ-018 SHALL use FSM states IDLE, SNAP, SETUP, STROBE, GAP, SEQ_SETUP, SEQ_STROBE.
REQ-019 SHALL go IDLE->SNAP on tick; in SNAP, capture ch_data and ch_mask into shadow registers and select the first enabled byte, or SEQ_SETUP if the mask is zero.
REQ-020 SHALL in SETUP drive datain/addrin for the current byte with en=0; STROBE SHALL drive en=1 for exactly one cycle with datain/addrin held.
REQ-021 SHALL make GAP last EN_GAP cycles with en=0 and outputs held, and skip it when EN_GAP=0.
REQ-022 SHALL, after GAP, advance to the next byte, then the next enabled channel, otherwise to SEQ_SETUP.
REQ-023 SHALL write BPC=DW/8 bytes per enabled channel, least-significant first, at addrin = ADDR_BASE + k*BPC + b.
REQ-024 SHALL leave masked channels unwritten and SHALL NOT compact addresses.
REQ-025 SHALL write a frame sequence byte at ADDR_BASE + NCH*BPC using SEQ_SETUP/SEQ_STROBE, followed by GAP then IDLE.
REQ-026 SHALL increment the sequence byte by 1 (mod 256) on leaving SEQ_STROBE.
REQ-027 SHALL assert the first en exactly 3 cycles after the tick cycle.
REQ-028 SHALL assert busy in every state except IDLE.
REQ-029 SHALL, on a tick while busy, drop the tick, set overrun, and leave the current frame and sequence unaffected.
REQ-030 SHALL clear overrun on clr_ovr; a simultaneous tick-while-busy SHALL win and set it.
REQ-031 SHALL ignore ch_data/ch_mask changes during a frame, using only the shadow values.
REQ-032 SHALL raise an elaboration error if ADDR_BASE + NCH*BPC > 2^AW-1 or DW%8 != 0.

Reset
REQ-033 SHALL on rst set datain=0, addrin=0, en=0, busy=0, overrun=0, sequence=0, tick counter=0, FSM=IDLE.
REQ-034 SHALL, on rst mid-frame, drive en low on the next cycle, abandon the frame, and write no further bytes.

Structure
REQ-035 SHALL place FSM state encoding and BPC/address-offset helper constants in the shared package sfw_pkg.
REQ-036 SHALL implement the tick divider as sub-module sfw_tick_gen (params TICK_DIV; ports clk100m, rst, tick); all other logic SHALL be flat.

Verification
REQ-037 SHALL cover default params with mask=6'h3F and X=16'h1234, then tick -> 13 strobes: addr 0..11 with data 34,12,… and addr 12 = 00; first en at tick+3; strobes 4 cycles apart.
REQ-038 SHALL cover mask=6'b000010 -> strobes only at addr 2, 3, 12; the next frame writes seq=01 at 12.
REQ-039 SHALL cover mask=0 -> a single strobe at addr 12 per frame; the sequence wraps FF->00 after 256 frames.
REQ-040 SHALL cover TICK_DIV=20 with the full mask (frame > 20 cycles) -> overrun=1 and the frame completes intact; clr_ovr clears it.
REQ-041 SHALL cover rst asserted during the 3rd byte's GAP -> en stays 0, all outputs 0 the next cycle, and a fresh frame restarts with seq=00.
REQ-042 SHALL cover NCH=2, DW=32, EN_GAP=0, ADDR_BASE=8'h10 -> addr 10..17 then 18, strobes 2 cycles apart, data byte order LSB first.
